// File: rtl/tmmix_pkg.sv
// Shared layer codes, enable reset value and attribute word for the tilemap layer mixer.
package tmmix_pkg;

   localparam int COL_W_DEF = 7;

   typedef enum logic [1:0] {
      LAYER_A        = 2'd0,
      LAYER_B        = 2'd1,
      LAYER_OBJ      = 2'd2,
      LAYER_BACKDROP = 2'd3
   } layer_e;

   // Enable bit order is {OBJ, B, A}.
   localparam logic [2:0] EN_RESET = 3'b111;

   typedef struct packed {
      logic [COL_W_DEF-1:0] col;
      logic                 prio;
   } attr_t;

endpackage

// File: rtl/tilemap_layer_mixer_if.sv
// Pixel, blanking and CPU-control bundle of the tilemap layer mixer.
// TMMIX_DEBUG_SOLO_EN adds the i_DBG_SOLO layer-solo select.
interface tilemap_layer_mixer_if #(
   parameter int COL_W = 7
);
   logic             i_CLK_px6;
   logic             i_TM_A_px_trans;
   logic [3:0]       i_TM_A_pixels;
   logic [COL_W-1:0] i_TM_A_col;
   logic             i_TM_A_prio;
   logic             i_TM_B_px_trans;
   logic [3:0]       i_TM_B_pixels;
   logic [COL_W-1:0] i_TM_B_col;
   logic             i_TM_B_prio;
   logic [3:0]       i_OBJ_pixels;
   logic [COL_W-1:0] i_OBJ_col;
   logic             i_HBLANK_n;
   logic             i_VBLANK_n;
   logic             i_CTRL_WR;
   logic [2:0]       i_CTRL_D;
`ifdef TMMIX_DEBUG_SOLO_EN
   logic [2:0]       i_DBG_SOLO;
`endif
   logic [COL_W+3:0] o_PAL_ADDR;
   logic [1:0]       o_LAYER;

   modport master (
      output i_CLK_px6, i_TM_A_px_trans, i_TM_A_pixels, i_TM_A_col, i_TM_A_prio,
      output i_TM_B_px_trans, i_TM_B_pixels, i_TM_B_col, i_TM_B_prio,
      output i_OBJ_pixels, i_OBJ_col, i_HBLANK_n, i_VBLANK_n, i_CTRL_WR, i_CTRL_D,
`ifdef TMMIX_DEBUG_SOLO_EN
      output i_DBG_SOLO,
`endif
      input  o_PAL_ADDR, o_LAYER
   );

   modport slave (
      input  i_CLK_px6, i_TM_A_px_trans, i_TM_A_pixels, i_TM_A_col, i_TM_A_prio,
      input  i_TM_B_px_trans, i_TM_B_pixels, i_TM_B_col, i_TM_B_prio,
      input  i_OBJ_pixels, i_OBJ_col, i_HBLANK_n, i_VBLANK_n, i_CTRL_WR, i_CTRL_D,
`ifdef TMMIX_DEBUG_SOLO_EN
      input  i_DBG_SOLO,
`endif
      output o_PAL_ADDR, o_LAYER
   );
endinterface

// File: rtl/tmmix_attr_delay.sv
// Clock-enabled shift register that realigns tile attributes with delayed pixel data.
module tmmix_attr_delay #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cen_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [DEPTH-1:0][WIDTH-1:0] stages_q;

   // NOTE: every stage is cleared so the first DEPTH pixels after reset see colour 0 / prio 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stages_q <= '0;
      end else if (cen_i) begin
         stages_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stages_q[i] <= stages_q[i-1];
         end
      end
   end

   assign q_o = stages_q[DEPTH-1];
endmodule

// File: rtl/tilemap_layer_mixer.sv
// Merges Tilemap A/B and object pixels into one palette address with per-tile priority.
// Optional TMMIX_DEBUG_SOLO_EN: i_DBG_SOLO = 1/2/3 shows only A/B/OBJ.
module tilemap_layer_mixer
   import tmmix_pkg::*;
#(
   parameter int A_ATTR_DLY = 5,
   parameter int B_ATTR_DLY = 4,
   parameter int COL_W      = COL_W_DEF
) (
   input logic                  i_MCLK,
   input logic                  i_RST_n,
   tilemap_layer_mixer_if.slave bus
);
   typedef struct packed {
      logic [COL_W-1:0] col;
      logic             prio;
   } attr_w_t;

   attr_w_t          a_attr, b_attr;
   logic [2:0]       shadow_q, shadow_d, active_q, active_d;
   logic             vblank_q, vblank_fall;
   logic             cand_a, cand_b, cand_o;
   logic [COL_W+3:0] pal_q, pal_d;
   layer_e           layer_q, layer_d;

   tmmix_attr_delay #(.DEPTH(A_ATTR_DLY), .WIDTH(COL_W + 1)) u_a_dly (
      .clk   (i_MCLK),
      .rst_n (i_RST_n),
      .cen_i (bus.i_CLK_px6),
      .d_i   ({bus.i_TM_A_col, bus.i_TM_A_prio}),
      .q_o   (a_attr)
   );

   tmmix_attr_delay #(.DEPTH(B_ATTR_DLY), .WIDTH(COL_W + 1)) u_b_dly (
      .clk   (i_MCLK),
      .rst_n (i_RST_n),
      .cen_i (bus.i_CLK_px6),
      .d_i   ({bus.i_TM_B_col, bus.i_TM_B_prio}),
      .q_o   (b_attr)
   );

   // Enables only move shadow -> active on the VBLANK falling edge, so a frame never mixes two sets.
   assign vblank_fall = vblank_q & ~bus.i_VBLANK_n;
   assign shadow_d    = bus.i_CTRL_WR ? bus.i_CTRL_D : shadow_q;
   assign active_d    = vblank_fall ? shadow_d : active_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_MCLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         shadow_q <= EN_RESET;
         active_q <= EN_RESET;
         vblank_q <= 1'b1;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         vblank_q <= bus.i_VBLANK_n;
      end
   end

   // NOTE: all outputs of this block get a default first so no latch is inferred.
   always_comb begin
      cand_a  = bus.i_TM_A_px_trans & active_q[0];
      cand_b  = bus.i_TM_B_px_trans & active_q[1];
      cand_o  = (bus.i_OBJ_pixels != 4'd0) & active_q[2];
`ifdef TMMIX_DEBUG_SOLO_EN
      case (bus.i_DBG_SOLO)
         3'd1:    begin cand_a = bus.i_TM_A_px_trans; cand_b = 1'b0; cand_o = 1'b0; end
         3'd2:    begin cand_a = 1'b0; cand_b = bus.i_TM_B_px_trans; cand_o = 1'b0; end
         3'd3:    begin cand_a = 1'b0; cand_b = 1'b0; cand_o = (bus.i_OBJ_pixels != 4'd0); end
         default: ;
      endcase
`endif
      pal_d   = '0;
      layer_d = LAYER_BACKDROP;
      if (cand_a && a_attr.prio) begin
         pal_d = {a_attr.col, bus.i_TM_A_pixels};  layer_d = LAYER_A;
      end else if (cand_b && b_attr.prio) begin
         pal_d = {b_attr.col, bus.i_TM_B_pixels};  layer_d = LAYER_B;
      end else if (cand_o) begin
         pal_d = {bus.i_OBJ_col, bus.i_OBJ_pixels}; layer_d = LAYER_OBJ;
      end else if (cand_a) begin
         pal_d = {a_attr.col, bus.i_TM_A_pixels};  layer_d = LAYER_A;
      end else if (cand_b) begin
         pal_d = {b_attr.col, bus.i_TM_B_pixels};  layer_d = LAYER_B;
      end
      if (!bus.i_HBLANK_n || !bus.i_VBLANK_n) begin
         pal_d   = '0;
         layer_d = LAYER_BACKDROP;
      end
   end

   always_ff @(posedge i_MCLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         pal_q   <= '0;
         layer_q <= LAYER_BACKDROP;
      end else if (bus.i_CLK_px6) begin
         pal_q   <= pal_d;
         layer_q <= layer_d;
      end
   end

   assign bus.o_PAL_ADDR = pal_q;
   assign bus.o_LAYER    = layer_q;
endmodule

// File: tb/tb_tilemap_layer_mixer.sv
// Directed self-checking bench for tilemap_layer_mixer (A delay 5, B delay 4, COL_W 7).
module tb_tilemap_layer_mixer;
   localparam int COL_W = 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   tilemap_layer_mixer_if #(.COL_W(COL_W)) bus ();

   tilemap_layer_mixer #(.A_ATTR_DLY(5), .B_ATTR_DLY(4), .COL_W(COL_W)) dut (
      .i_MCLK  (clk),
      .i_RST_n (rst_n),
      .bus     (bus.slave)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input int pal, input int layer);
      check({tag, "_pal"},   int'(bus.o_PAL_ADDR), pal);
      check({tag, "_layer"}, int'(bus.o_LAYER),    layer);
   endtask

   // One pixel: i_CLK_px6 high for exactly one i_MCLK cycle; returns on a falling edge.
   task automatic pixel();
      @(negedge clk) bus.i_CLK_px6 = 1'b1;
      @(negedge clk) bus.i_CLK_px6 = 1'b0;
   endtask

   task automatic pixels(input int n);
      for (int i = 0; i < n; i++) pixel();
   endtask

   task automatic ctrl_write(input logic [2:0] d);
      @(negedge clk) begin bus.i_CTRL_WR = 1'b1; bus.i_CTRL_D = d; end
      @(negedge clk) bus.i_CTRL_WR = 1'b0;
   endtask

   task automatic set_a(input logic t, input logic [3:0] px, input logic [6:0] col, input logic pr);
      bus.i_TM_A_px_trans = t; bus.i_TM_A_pixels = px; bus.i_TM_A_col = col; bus.i_TM_A_prio = pr;
   endtask

   task automatic set_b(input logic t, input logic [3:0] px, input logic [6:0] col, input logic pr);
      bus.i_TM_B_px_trans = t; bus.i_TM_B_pixels = px; bus.i_TM_B_col = col; bus.i_TM_B_prio = pr;
   endtask

   initial begin
      bus.i_CLK_px6 = 1'b0;
      set_a(1'b0, 4'h0, 7'h00, 1'b0);
      set_b(1'b0, 4'h0, 7'h00, 1'b0);
      bus.i_OBJ_pixels = 4'h0; bus.i_OBJ_col = 7'h00;
      bus.i_HBLANK_n = 1'b1; bus.i_VBLANK_n = 1'b1;
      bus.i_CTRL_WR = 1'b0; bus.i_CTRL_D = 3'b000;
`ifdef TMMIX_DEBUG_SOLO_EN
      bus.i_DBG_SOLO = 3'd0;
`endif
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_out("reset", 0, 3);
      rst_n = 1'b1;

      // Alignment: first 5 pixels after reset carry colour 0, then the A colour appears.
      set_a(1'b1, 4'h3, 7'h10, 1'b0);
      pixel();    check_out("rst_col0_first", 'h003, 0);
      pixels(4);  check_out("rst_col0_fifth", 'h003, 0);
      pixel();    check_out("align_col10",    'h103, 0);
      set_a(1'b1, 4'h3, 7'h22, 1'b0);
      pixels(5);  check_out("align_k_plus4",  'h103, 0);
      pixel();    check_out("align_k_plus5",  'h223, 0);

      // Priority ladder.
      set_a(1'b1, 4'h5, 7'h22, 1'b0);
      bus.i_OBJ_pixels = 4'h9; bus.i_OBJ_col = 7'h40;
      pixel();    check_out("obj_over_lowA",  'h409, 2);
      set_a(1'b1, 4'h5, 7'h22, 1'b1);
      pixels(5);  check_out("prioA_pending",  'h409, 2);
      pixel();    check_out("prioA_wins",     'h225, 0);
      set_b(1'b1, 4'h7, 7'h33, 1'b0);
      pixel();    check_out("prioA_over_B",   'h225, 0);
      set_a(1'b1, 4'h5, 7'h22, 1'b0);
      set_b(1'b1, 4'h7, 7'h33, 1'b1);
      pixels(6);  check_out("prioB_over_obj", 'h337, 1);
      set_b(1'b1, 4'h7, 7'h33, 1'b0);
      pixels(5);  check_out("obj_over_lowB",  'h409, 2);
      bus.i_OBJ_pixels = 4'h0;
      pixel();    check_out("lowA_over_lowB", 'h225, 0);
      bus.i_TM_A_px_trans = 1'b0;
      pixel();    check_out("lowB_only",      'h337, 1);
      bus.i_TM_B_px_trans = 1'b0;
      pixel();    check_out("all_transparent", 0, 3);

      // Horizontal blanking forces backdrop even with every layer opaque.
      bus.i_TM_A_px_trans = 1'b1; bus.i_TM_B_px_trans = 1'b1; bus.i_OBJ_pixels = 4'h9;
      bus.i_HBLANK_n = 1'b0;
      pixel();    check_out("hblank",         0, 3);
      bus.i_HBLANK_n = 1'b1;
      pixel();    check_out("hblank_release", 'h409, 2);

      // Shadowed enables: disabling A mid-frame waits for the VBLANK falling edge.
      bus.i_OBJ_pixels = 4'h0;
      ctrl_write(3'b110);
      pixel();    check_out("en_midframe",    'h225, 0);
      bus.i_VBLANK_n = 1'b0;
      pixel();    check_out("vblank",         0, 3);
      bus.i_VBLANK_n = 1'b1;
      pixel();    check_out("en_next_frame",  'h337, 1);

      // Write coinciding with the falling edge applies at that edge: OBJ off, A back on.
      @(negedge clk) begin bus.i_VBLANK_n = 1'b0; bus.i_CTRL_WR = 1'b1; bus.i_CTRL_D = 3'b011; end
      @(negedge clk) bus.i_CTRL_WR = 1'b0;
      bus.i_VBLANK_n = 1'b1;
      bus.i_TM_A_px_trans = 1'b0; bus.i_TM_B_px_trans = 1'b0; bus.i_OBJ_pixels = 4'h9;
      pixel();    check_out("coinc_obj_off",  0, 3);
      bus.i_TM_A_px_trans = 1'b1;
      pixel();    check_out("coinc_a_on",     'h225, 0);

      // Asynchronous reset between pixels, then enables back to all-on.
      @(negedge clk);
      #3 rst_n = 1'b0;
      #1 check_out("async_reset", 0, 3);
      @(negedge clk) rst_n = 1'b1;
      bus.i_TM_A_px_trans = 1'b0;
      pixel();    check_out("rst_en_obj",     'h409, 2);
      bus.i_TM_A_px_trans = 1'b1; bus.i_OBJ_pixels = 4'h0;
      pixel();    check_out("rst_a_col0",     'h005, 0);

`ifdef TMMIX_DEBUG_SOLO_EN
      set_a(1'b1, 4'h5, 7'h22, 1'b1);
      set_b(1'b1, 4'h7, 7'h33, 1'b0);
      pixels(6);  check_out("solo_off",       'h225, 0);
      bus.i_DBG_SOLO = 3'd2;
      pixel();    check_out("solo_b",         'h337, 1);
      bus.i_DBG_SOLO = 3'd0;
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/tilemap_layer_mixer.md
Name: tilemap_layer_mixer

Overview:
Downstream consumer of the K005290 tileline latch outputs. It merges Tilemap A pixels, Tilemap B pixels and object (sprite) pixels into one palette address per pixel, using per-tile priority bits. Tile colour attributes pass through per-layer delay lines so they line up with the delayed pixel data. Layer enables are written by the CPU through a shadow register that takes effect at the start of vertical blank.

Parameters:
A_ATTR_DLY, 5, px6 periods of delay applied to Tilemap A attribute/prio (legal 1..15)
B_ATTR_DLY, 4, px6 periods of delay applied to Tilemap B attribute/prio (legal 1..15)
COL_W, 7, colour-code width; palette address width = COL_W+4

Ports:
i_MCLK  in  1  main clock 48 MHz
i_RST_n  in  1  reset, asynchronous, active-low
i_CLK_px6  in  1  pixel clock-enable, one i_MCLK cycle high per pixel
i_TM_A_px_trans  in  1  Tilemap A opaque flag (low = transparent)
i_TM_A_pixels  in  4  Tilemap A pixel
i_TM_A_col  in  COL_W  Tilemap A tile colour code, undelayed
i_TM_A_prio  in  1  Tilemap A tile priority, undelayed
i_TM_B_px_trans  in  1  Tilemap B opaque flag (low = transparent)
i_TM_B_pixels  in  4  Tilemap B pixel
i_TM_B_col  in  COL_W  Tilemap B colour code, undelayed
i_TM_B_prio  in  1  Tilemap B priority, undelayed
i_OBJ_pixels  in  4  object pixel (0 = transparent)
i_OBJ_col  in  COL_W  object colour code, already aligned
i_HBLANK_n  in  1  horizontal blank, active-low
i_VBLANK_n  in  1  vertical blank, active-low
i_CTRL_WR  in  1  CPU write strobe, one i_MCLK cycle
i_CTRL_D  in  3  layer enables {OBJ, B, A}
o_PAL_ADDR  out  COL_W+4  {colour, pixel}
o_LAYER  out  2  winner: 0 = A, 1 = B, 2 = OBJ, 3 = backdrop

Behaviour:
- Reset values: o_PAL_ADDR = 0; o_LAYER = 3. All delay stages are 0. Shadow enables = 3'b111; active enables = 3'b111. VBLANK edge detector register = 1.
- State advances only on i_MCLK edges where i_CLK_px6 = 1. The exceptions are the control path and the VBLANK edge detector, which run every i_MCLK.
- Delay lines: each cen shifts {col, prio} in. The tap at depth X_ATTR_DLY feeds the resolver. The undelayed value sampled at cen k is used at cen k+X_ATTR_DLY.
- Each layer has a candidate flag:
  - candA = trans_A & en_A
  - candB = trans_B & en_B
  - candO = (OBJ_pixels != 0) & en_O
- Fixed priority, highest first:
  1. candA & prioA_d
  2. candB & prioB_d
  3. candO
  4. candA
  5. candB
  6. backdrop
- Backdrop output: o_PAL_ADDR = 0, o_LAYER = 3.
- Latency: pixel inputs sampled at cen k produce a registered result on o_PAL_ADDR/o_LAYER at the end of cen k. The output holds until the next cen.
- Blanking: if i_HBLANK_n = 0 or i_VBLANK_n = 0 at the cen, the output is forced to backdrop. Delay lines still shift during blanking.
- Control path:
  - i_CTRL_WR loads the shadow register on any i_MCLK cycle.
  - Active enables load from the shadow on the first i_MCLK where i_VBLANK_n is 0 after having been 1 (falling edge).
  - If a write and the falling edge occur in the same cycle, active takes the new i_CTRL_D directly.
  - An enable change never takes effect mid-frame.
- Asserting reset mid-line clears everything immediately. After release, the first X_ATTR_DLY pixels use colour 0 / prio 0.

Optional Feature:
TMMIX_DEBUG_SOLO_EN
- Defined: adds input i_DBG_SOLO[2:0].
  - 0 = normal.
  - 1/2/3 = show only A/B/OBJ, ignoring priority and enables. Every other layer is treated as transparent.
  - 4..7 = normal.
  - Blanking still applies.
- Undefined: no port, no logic; behaviour is exactly normal mode.

Decomposition:
- Package tmmix_pkg:
  - LAYER_A = 2'd0, LAYER_B = 2'd1, LAYER_OBJ = 2'd2, LAYER_BACKDROP = 2'd3
  - default COL_W
  - reset enable constant 3'b111
  - typedef for the {col, prio} attribute word
- Sub-module tmmix_attr_delay, instantiated once per tilemap: parameterised depth and width, clock-enabled shift register, async active-low clear.

Test Plan:
- Alignment: A_ATTR_DLY = 5; A opaque pixel 4'h3; A_col changes 7'h10→7'h22 at cen k → o_PAL_ADDR shows {7'h10, 4'h3} through cen k+4 and {7'h22, 4'h3} at cen k+5.
- Priority: A = 4'h5 prio 0, OBJ = 4'h9 col 7'h40, B transparent → {7'h40, 4'h9}, LAYER = 2. Set delayed A prio = 1 → A wins, LAYER = 0.
- All transparent or disabled: A and B trans low, OBJ = 0 → o_PAL_ADDR = 0, o_LAYER = 3. Same result with all opaque but HBLANK_n = 0.
- Enable shadow: write 3'b110 mid-frame → A still visible until VBLANK_n falls. Next frame A is never the winner. Write coincident with the falling edge takes effect at that edge.
- Reset: assert i_RST_n = 0 asynchronously between cens → o_PAL_ADDR = 0 and o_LAYER = 3 immediately. Enables return to 3'b111.
- Debug (macro defined): i_DBG_SOLO = 2 with A high-prio opaque and B opaque 4'h7 → LAYER = 1, pixel 4'h7.
